// File: rtl/microroc_sc_load_scheduler_pkg.sv
// microroc_sc_pkg: shared FSM state encoding and serializer length constants
// for the MICROROC slow-control / read-scope load scheduler.
package microroc_sc_pkg;
    localparam int SC_BIT_LENGTH = 592;
    localparam int RR_BIT_LENGTH = 64;
    localparam int SHIFT_LEN_W   = 10;
    typedef enum logic [2:0] {IDLE, SELECT, START, SHIFT, DONE, ERR, SETTLE} state_t;
    function automatic logic [SHIFT_LEN_W-1:0] shift_len(input logic mode, input int sc_len, input int rr_len);
        return mode ? SHIFT_LEN_W'(sc_len) : SHIFT_LEN_W'(rr_len);
    endfunction
endpackage

// File: rtl/microroc_sc_load_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending chain
// after the previously granted one, wrapping around.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_pending,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_grant,
    output logic          o_valid
);
    logic [PW-1:0] w_idx;
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        // Walk from farthest to nearest so the chain right after i_ptr wins.
        for (int i = N; i >= 1; i--) begin
            w_idx = PW'((int'(i_ptr) + i) % N);
            if (i_pending[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/microroc_sc_load_scheduler.sv
// microroc_sc_load_scheduler: round-robin sequencing of per-chain MICROROC parameter
// loads onto one shared serializer, with timeout, settle gap and abort.
module microroc_sc_load_scheduler #(
    parameter int ASIC_CHAIN_NUMBER = 4,
    parameter int SC_BIT_LENGTH     = microroc_sc_pkg::SC_BIT_LENGTH,
    parameter int RR_BIT_LENGTH     = microroc_sc_pkg::RR_BIT_LENGTH,
    parameter int SETTLE_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                                   Clk,
    input  logic                                   reset,
    input  logic [ASIC_CHAIN_NUMBER-1:0]           LoadRequest,
    input  logic [ASIC_CHAIN_NUMBER-1:0]           LoadModeSlowControl,
    input  logic                                   AbortAll,
    input  logic                                   ErrorClear,
    input  logic                                   ShiftDone,
    output logic [ASIC_CHAIN_NUMBER-1:0]           ChainSelect,
    output logic [ASIC_CHAIN_NUMBER-1:0]           SlowOrReadScopeSelect,
    output logic                                   ShiftStart,
    output logic [microroc_sc_pkg::SHIFT_LEN_W-1:0] ShiftLength,
    output logic                                   Busy,
    output logic [ASIC_CHAIN_NUMBER-1:0]           LoadDone,
    output logic [ASIC_CHAIN_NUMBER-1:0]           LoadError
);
    import microroc_sc_pkg::*;

    localparam int N  = ASIC_CHAIN_NUMBER;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    if (SC_BIT_LENGTH >= (1 << SHIFT_LEN_W) || RR_BIT_LENGTH >= (1 << SHIFT_LEN_W)) begin : g_len_overflow
        $error("ShiftLength constants do not fit in %0d bits", SHIFT_LEN_W);
    end

    state_t        r_state;
    logic [N-1:0]  r_pending;
    logic [PW-1:0] r_ptr;
    logic [TW-1:0] r_tmo_cnt;
    logic [SW-1:0] r_settle_cnt;
    logic          r_rereq;
    logic [PW-1:0] w_grant;
    logic          w_grant_valid;
    logic [N-1:0]  w_ptr_oh;
    logic          w_timeout;
    logic          w_shift_end;
    logic [N-1:0]  w_clr;

    rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_grant   (w_grant),
        .o_valid   (w_grant_valid)
    );

    assign w_ptr_oh    = N'(1) << r_ptr;
    assign w_timeout   = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_shift_end = (r_state == SHIFT) && (ShiftDone || w_timeout) && !AbortAll;
    // A re-request of the active chain made after its grant keeps it pending for a second load.
    assign w_clr       = (w_shift_end && !r_rereq) ? w_ptr_oh : '0;
    assign Busy        = (r_state != IDLE);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state               <= IDLE;
            r_pending             <= '0;
            r_ptr                 <= PW'(N - 1);
            r_tmo_cnt             <= '0;
            r_settle_cnt          <= '0;
            r_rereq               <= 1'b0;
            ChainSelect           <= '0;
            SlowOrReadScopeSelect <= '0;
            ShiftStart            <= 1'b0;
            ShiftLength           <= '0;
            LoadDone              <= '0;
            LoadError             <= '0;
        end else begin
            r_pending  <= AbortAll ? '0 : (r_pending & ~w_clr) | LoadRequest;
            r_rereq    <= (AbortAll || r_state == IDLE) ? 1'b0 : r_rereq | LoadRequest[r_ptr];
            LoadDone   <= '0;
            ShiftStart <= 1'b0;
            if (ErrorClear)
                LoadError <= '0;
            if (AbortAll) begin
                r_state     <= IDLE;
                ChainSelect <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_grant_valid) begin
                            r_ptr   <= w_grant;
                            r_state <= SELECT;
                        end
                    end
                    SELECT: begin
                        ChainSelect                  <= w_ptr_oh;
                        SlowOrReadScopeSelect[r_ptr] <= LoadModeSlowControl[r_ptr];
                        ShiftLength                  <= shift_len(LoadModeSlowControl[r_ptr], SC_BIT_LENGTH, RR_BIT_LENGTH);
                        ShiftStart                   <= 1'b1;
                        r_state                      <= START;
                    end
                    START: begin
                        r_tmo_cnt <= '0;
                        r_state   <= SHIFT;
                    end
                    SHIFT: begin
                        if (ShiftDone) begin
                            LoadDone <= w_ptr_oh;
                            r_state  <= DONE;
                        end else if (w_timeout) begin
                            LoadError[r_ptr] <= 1'b1;
                            r_state          <= ERR;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end
                    DONE, ERR: begin
                        r_settle_cnt <= SW'(SETTLE_CYCLES - 1);
                        r_state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (r_settle_cnt == '0) begin
                            ChainSelect <= '0;
                            r_state     <= IDLE;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_microroc_sc_load_scheduler.sv
// tb_microroc_sc_load_scheduler: directed scoreboard bench for the load scheduler.
module tb_microroc_sc_load_scheduler;
    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] LoadRequest = '0;
    logic [3:0] LoadModeSlowControl = '0;
    logic       AbortAll = 1'b0;
    logic       ErrorClear = 1'b0;
    logic       ShiftDone = 1'b0;
    logic [3:0] ChainSelect;
    logic [3:0] SlowOrReadScopeSelect;
    logic       ShiftStart;
    logic [9:0] ShiftLength;
    logic       Busy;
    logic [3:0] LoadDone;
    logic [3:0] LoadError;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int ch;
        int len;
        bit mode;
        bit err;
    } exp_t;
    exp_t sb[$];

    microroc_sc_load_scheduler dut (
        .Clk                   (Clk),
        .reset                 (reset),
        .LoadRequest           (LoadRequest),
        .LoadModeSlowControl   (LoadModeSlowControl),
        .AbortAll              (AbortAll),
        .ErrorClear            (ErrorClear),
        .ShiftDone             (ShiftDone),
        .ChainSelect           (ChainSelect),
        .SlowOrReadScopeSelect (SlowOrReadScopeSelect),
        .ShiftStart            (ShiftStart),
        .ShiftLength           (ShiftLength),
        .Busy                  (Busy),
        .LoadDone              (LoadDone),
        .LoadError             (LoadError)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int ch, input logic [3:0] m, input bit err);
        exp_t e;
        e.ch   = ch;
        e.mode = m[ch];
        e.len  = m[ch] ? 592 : 64;
        e.err  = err;
        return e;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        LoadRequest = '0;
        AbortAll = 1'b0;
        ErrorClear = 1'b0;
        ShiftDone = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        sb.delete();
    endtask

    task automatic pulse_req(input logic [3:0] r);
        LoadRequest = r;
        tick();
        LoadRequest = '0;
    endtask

    // Pops the next expected grant and waits (bounded) for its ShiftStart.
    task automatic expect_grant(output exp_t e, output int n);
        n = 0;
        e = mk(0, 4'b0000, 1'b0);
        check("sb_level", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0)
            e = sb.pop_front();
        while (ShiftStart !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("start_seen", 32'(ShiftStart), 32'd1);
        check("chain_sel", 32'(ChainSelect), 32'(1 << e.ch));
        check("shift_len", 32'(ShiftLength), 32'(e.len));
        check("sros_bit", 32'(SlowOrReadScopeSelect[e.ch]), 32'(e.mode));
    endtask

    task automatic finish_ok(input exp_t e, input int dly, input logic [3:0] mid_req);
        tick();
        LoadRequest = mid_req;
        tick();
        LoadRequest = '0;
        repeat (dly) tick();
        check("busy_in_shift", 32'(Busy), 32'd1);
        check("no_early_done", 32'(LoadDone), 32'd0);
        ShiftDone = 1'b1;
        tick();
        ShiftDone = 1'b0;
        check("load_done", 32'(LoadDone), 32'(1 << e.ch));
        tick();
        check("load_done_1cyc", 32'(LoadDone), 32'd0);
    endtask

    task automatic finish_timeout(input exp_t e);
        repeat (4096) tick();
        check("err_not_early", 32'(LoadError[e.ch]), 32'd0);
        tick();
        check("err_set", 32'(LoadError[e.ch]), 32'd1);
        check("err_no_done", 32'(LoadDone), 32'd0);
        tick();
    endtask

    initial begin
        exp_t e;
        int   n;
        #1;
        check("rst_chain_sel", 32'(ChainSelect), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_start", 32'(ShiftStart), 32'd0);
        check("rst_len", 32'(ShiftLength), 32'd0);
        check("rst_err", 32'(LoadError), 32'd0);
        do_reset();

        // 1: single request, exact latency, 600-cycle shift and settle length
        LoadModeSlowControl = 4'b0001;
        LoadRequest = 4'b0001;
        sb.push_back(mk(0, LoadModeSlowControl, 1'b0));
        tick();
        LoadRequest = '0;
        check("lat_k1_idle", 32'(Busy), 32'd0);
        tick();
        check("lat_k2_busy", 32'(Busy), 32'd1);
        check("lat_k2_nostart", 32'(ShiftStart), 32'd0);
        tick();
        expect_grant(e, n);
        check("lat_k3_start", 32'(n), 32'd0);
        tick();
        check("start_1cyc", 32'(ShiftStart), 32'd0);
        finish_ok(e, 597, 4'b0000);
        repeat (15) tick();
        check("settle_last_sel", 32'(ChainSelect), 32'd1);
        tick();
        check("settle_end_sel", 32'(ChainSelect), 32'd0);
        check("settle_end_busy", 32'(Busy), 32'd0);

        // 2: round robin 0,1,3 twice, chain 1 in read-scope mode
        do_reset();
        LoadModeSlowControl = 4'b1101;
        for (int r = 0; r < 2; r++) begin
            sb.push_back(mk(0, LoadModeSlowControl, 1'b0));
            sb.push_back(mk(1, LoadModeSlowControl, 1'b0));
            sb.push_back(mk(3, LoadModeSlowControl, 1'b0));
            pulse_req(4'b1011);
            for (int i = 0; i < 3; i++) begin
                expect_grant(e, n);
                if (i > 0)
                    check("b2b_spacing", 32'(n), 32'd18);
                finish_ok(e, 4, 4'b0000);
            end
        end

        // 3: timeout on chain 0, ErrorClear, then chain 2 served
        do_reset();
        LoadModeSlowControl = 4'b0001;
        sb.push_back(mk(0, LoadModeSlowControl, 1'b1));
        sb.push_back(mk(2, LoadModeSlowControl, 1'b0));
        pulse_req(4'b0101);
        expect_grant(e, n);
        finish_timeout(e);
        check("err_vec", 32'(LoadError), 32'd1);
        ErrorClear = 1'b1;
        tick();
        ErrorClear = 1'b0;
        check("err_cleared", 32'(LoadError), 32'd0);
        expect_grant(e, n);
        finish_ok(e, 5, 4'b0000);
        check("err_stays_clear", 32'(LoadError), 32'd0);

        // 4: chain 2 re-requests during its own shift while chain 0 is also requested
        LoadModeSlowControl = 4'b0101;
        sb.push_back(mk(2, LoadModeSlowControl, 1'b0));
        sb.push_back(mk(0, LoadModeSlowControl, 1'b0));
        sb.push_back(mk(2, LoadModeSlowControl, 1'b0));
        repeat (20) tick();
        pulse_req(4'b0100);
        expect_grant(e, n);
        finish_ok(e, 10, 4'b0101);
        expect_grant(e, n);
        finish_ok(e, 3, 4'b0000);
        expect_grant(e, n);
        finish_ok(e, 3, 4'b0000);
        repeat (16) tick();
        check("rereq_drained", 32'(Busy), 32'd0);

        // 5: AbortAll during SHIFT with three chains pending, late ShiftDone ignored
        do_reset();
        LoadModeSlowControl = 4'b1111;
        sb.push_back(mk(1, LoadModeSlowControl, 1'b0));
        pulse_req(4'b1110);
        expect_grant(e, n);
        repeat (2) tick();
        AbortAll = 1'b1;
        tick();
        AbortAll = 1'b0;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_sel", 32'(ChainSelect), 32'd0);
        check("abort_start", 32'(ShiftStart), 32'd0);
        check("abort_done", 32'(LoadDone), 32'd0);
        ShiftDone = 1'b1;
        tick();
        ShiftDone = 1'b0;
        check("late_done_ignored", 32'(LoadDone), 32'd0);
        repeat (5) tick();
        check("abort_pending_clr", 32'(Busy), 32'd0);

        // 6: async reset in SETTLE, then chain 0 is served before chain 3
        do_reset();
        LoadModeSlowControl = 4'b1001;
        sb.push_back(mk(0, LoadModeSlowControl, 1'b0));
        pulse_req(4'b0001);
        expect_grant(e, n);
        finish_ok(e, 3, 4'b0000);
        repeat (3) tick();
        check("pre_rst_busy", 32'(Busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_sel", 32'(ChainSelect), 32'd0);
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_len", 32'(ShiftLength), 32'd0);
        check("arst_sros", 32'(SlowOrReadScopeSelect), 32'd0);
        sb.delete();
        tick();
        reset = 1'b0;
        sb.push_back(mk(0, LoadModeSlowControl, 1'b0));
        sb.push_back(mk(3, LoadModeSlowControl, 1'b0));
        pulse_req(4'b1001);
        for (int i = 0; i < 2; i++) begin
            expect_grant(e, n);
            finish_ok(e, 2, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
